// File: rtl/sram_arbiter.sv
// N-channel round-robin arbiter time-sharing one asynchronous 16-bit SRAM.
// Optional macro PRIORITY_CH0_EN: channel 0 wins every arbitration it requests.
module sram_arbiter #(
   parameter int NUM_CH      = 3,
   parameter int ADDR_W      = 20,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic [NUM_CH-1:0]        req,
   input  logic [NUM_CH-1:0]        we,
   input  logic [NUM_CH*ADDR_W-1:0] addr,
   input  logic [NUM_CH*DATA_W-1:0] wdata,
   input  logic [NUM_CH*2-1:0]      be,
   output logic [NUM_CH-1:0]        ack,
   output logic [DATA_W-1:0]        rdata,
   output logic                     busy,
   output logic [ADDR_W-1:0]        SRAM_ADDR,
   inout  wire  [DATA_W-1:0]        SRAM_DQ,
   output logic                     SRAM_CE_N,
   output logic                     SRAM_OE_N,
   output logic                     SRAM_WE_N,
   output logic                     SRAM_UB_N,
   output logic                     SRAM_LB_N,
   output logic [1:0]               o_dbg_state
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

`ifdef PRIORITY_CH0_EN
   localparam bit PRIO0 = 1'b1;
`else
   localparam bit PRIO0 = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t              r_state;
   logic [CH_W-1:0]     r_rr;
   logic [CH_W-1:0]     r_gnt;
   logic                r_we;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_dq_oe;
   logic [CNT_W-1:0]    r_cnt;

   logic                w_any;
   logic [CH_W-1:0]     w_gnt;
   logic [CH_W:0]       w_sum;
   logic [CH_W-1:0]     w_sel;

   // Walk offsets from the far end down so the channel closest to r_rr wins.
   always_comb begin
      w_any = 1'b0;
      w_gnt = '0;
      w_sum = '0;
      w_sel = '0;
      for (int k = NUM_CH-1; k >= 0; k--) begin
         w_sum = {1'b0, r_rr} + (CH_W+1)'(k);
         w_sel = CH_W'((w_sum >= (CH_W+1)'(NUM_CH)) ? w_sum - (CH_W+1)'(NUM_CH) : w_sum);
         if (req[w_sel] && !(PRIO0 && (w_sel == '0))) begin
            w_any = 1'b1;
            w_gnt = w_sel;
         end
      end
      if (PRIO0 && req[0]) begin
         w_any = 1'b1;
         w_gnt = '0;
      end
   end

   assign SRAM_DQ     = r_dq_oe ? r_wdata : {DATA_W{1'bz}};
   assign o_dbg_state = r_state;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state   <= S_IDLE;
         r_rr      <= '0;
         r_gnt     <= '0;
         r_we      <= 1'b0;
         r_wdata   <= '0;
         r_dq_oe   <= 1'b0;
         r_cnt     <= '0;
         ack       <= '0;
         rdata     <= '0;
         busy      <= 1'b0;
         SRAM_ADDR <= '0;
         SRAM_CE_N <= 1'b1;
         SRAM_OE_N <= 1'b1;
         SRAM_WE_N <= 1'b1;
         SRAM_UB_N <= 1'b1;
         SRAM_LB_N <= 1'b1;
      end else begin
         ack <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state   <= S_ACCESS;
                  busy      <= 1'b1;
                  r_gnt     <= w_gnt;
                  r_we      <= we[w_gnt];
                  r_wdata   <= wdata[w_gnt*DATA_W +: DATA_W];
                  r_dq_oe   <= we[w_gnt];
                  r_cnt     <= CNT_W'(WAIT_CYCLES-1);
                  SRAM_ADDR <= addr[w_gnt*ADDR_W +: ADDR_W];
                  SRAM_CE_N <= 1'b0;
                  SRAM_OE_N <= we[w_gnt];
                  SRAM_WE_N <= ~we[w_gnt];
                  SRAM_UB_N <= ~be[{w_gnt, 1'b1}];
                  SRAM_LB_N <= ~be[{w_gnt, 1'b0}];
               end
            end
            S_ACCESS: begin
               if (r_cnt == '0) begin
                  r_state    <= S_DONE;
                  ack[r_gnt] <= 1'b1;
                  SRAM_OE_N  <= 1'b1;
                  SRAM_WE_N  <= 1'b1;
                  if (!r_we) rdata <= SRAM_DQ;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DONE: begin
               // CE_N, address and write data stay put one more cycle for SRAM hold time.
               r_state   <= S_IDLE;
               busy      <= 1'b0;
               r_dq_oe   <= 1'b0;
               SRAM_CE_N <= 1'b1;
               SRAM_UB_N <= 1'b1;
               SRAM_LB_N <= 1'b1;
               if (!PRIO0 || (r_gnt != '0))
                  r_rr <= (r_gnt == CH_W'(NUM_CH-1)) ? '0 : r_gnt + 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: SRAM device model plus a transaction-level
// reference model (memory image, rdata, round-robin grant order).
`timescale 1ns/1ps
module tb_sram_arbiter;

   localparam int NUM_CH      = 3;
   localparam int ADDR_W      = 20;
   localparam int DATA_W      = 16;
   localparam int WAIT_CYCLES = 2;
   localparam int PERIOD      = WAIT_CYCLES + 2;

   logic                     Clk = 1'b0;
   logic                     Reset_n;
   logic [NUM_CH-1:0]        req;
   logic [NUM_CH-1:0]        we;
   logic [NUM_CH*ADDR_W-1:0] addr;
   logic [NUM_CH*DATA_W-1:0] wdata;
   logic [NUM_CH*2-1:0]      be;
   wire  [NUM_CH-1:0]        ack;
   wire  [DATA_W-1:0]        rdata;
   wire                      busy;
   wire  [ADDR_W-1:0]        SRAM_ADDR;
   wire  [DATA_W-1:0]        SRAM_DQ;
   wire                      SRAM_CE_N;
   wire                      SRAM_OE_N;
   wire                      SRAM_WE_N;
   wire                      SRAM_UB_N;
   wire                      SRAM_LB_N;
   wire  [1:0]               dbg_state;

   sram_arbiter #(
      .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT_CYCLES)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .be(be), .ack(ack), .rdata(rdata), .busy(busy), .SRAM_ADDR(SRAM_ADDR),
      .SRAM_DQ(SRAM_DQ), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
      .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
      .o_dbg_state(dbg_state)
   );

   // clock / watchdog
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // SRAM device model: 256 words (low address byte), byte-lane writes while WE_N low.
   logic [DATA_W-1:0] sram_mem [256] = '{default: '0};
   assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? sram_mem[SRAM_ADDR[7:0]] : 'z;

   always @(negedge Clk) begin
      if (Reset_n && !SRAM_CE_N && !SRAM_WE_N) begin
         if (!SRAM_UB_N) sram_mem[SRAM_ADDR[7:0]][15:8] = SRAM_DQ[15:8];
         if (!SRAM_LB_N) sram_mem[SRAM_ADDR[7:0]][7:0]  = SRAM_DQ[7:0];
      end
   end

   // scoreboard / reference model
   int                n_checks = 0;
   int                n_errors = 0;
   logic [DATA_W-1:0] ref_mem [256] = '{default: '0};
   logic [DATA_W-1:0] exp_rdata = '0;
   int                model_rr = 0;

   logic              op_we [NUM_CH];
   logic [ADDR_W-1:0] op_a  [NUM_CH];
   logic [DATA_W-1:0] op_d  [NUM_CH];
   logic [1:0]        op_b  [NUM_CH];

`ifdef PRIORITY_CH0_EN
   int dir_order [6] = '{0, 1, 0, 2, 0, 1};
`else
   int dir_order [6] = '{0, 1, 2, 0, 1, 2};
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int model_pick(input logic [NUM_CH-1:0] pend, input int rr);
`ifdef PRIORITY_CH0_EN
      if (pend[0]) return 0;
      for (int k = 0; k < NUM_CH; k++) begin
         int c;
         c = (rr + k) % NUM_CH;
         if (c != 0 && pend[c]) return c;
      end
`else
      for (int k = 0; k < NUM_CH; k++) begin
         int c;
         c = (rr + k) % NUM_CH;
         if (pend[c]) return c;
      end
`endif
      return -1;
   endfunction

   task automatic model_grant_done(input int g);
`ifdef PRIORITY_CH0_EN
      if (g != 0) model_rr = (g + 1) % NUM_CH;
`else
      model_rr = (g + 1) % NUM_CH;
`endif
   endtask

   task automatic model_access(input logic w, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input logic [1:0] b);
      logic [DATA_W-1:0] old;
      old = ref_mem[a[7:0]];
      if (w) ref_mem[a[7:0]] = {b[1] ? d[15:8] : old[15:8], b[0] ? d[7:0] : old[7:0]};
      else   exp_rdata = old;
   endtask

   function automatic int ack_idx(input logic [NUM_CH-1:0] a);
      for (int i = 0; i < NUM_CH; i++) if (a[i]) return i;
      return -1;
   endfunction

   // drivers
   task automatic set_ch(input int ch, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [1:0] b);
      op_we[ch] = w;
      op_a[ch]  = a;
      op_d[ch]  = d;
      op_b[ch]  = b;
      we[ch]                      = w;
      addr[ch*ADDR_W +: ADDR_W]   = a;
      wdata[ch*DATA_W +: DATA_W]  = d;
      be[ch*2 +: 2]               = b;
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr();
      logic [ADDR_W-1:0] a;
      a = ADDR_W'($urandom);
      a[7:4] = 4'h0;
      return a;
   endfunction

   task automatic new_op(input int ch);
      set_ch(ch, 1'($urandom_range(0, 1)), rand_addr(), DATA_W'($urandom), 2'($urandom_range(0, 3)));
   endtask

   task automatic check_done(input string tag, input int g);
      model_access(op_we[g], op_a[g], op_d[g], op_b[g]);
      chk({tag, "_rdata"}, rdata, exp_rdata);
      if (op_we[g]) chk({tag, "_mem"}, sram_mem[op_a[g][7:0]], ref_mem[op_a[g][7:0]]);
      model_grant_done(g);
   endtask

   // One isolated access with bus monitoring until its ack.
   task automatic run_one(input int ch, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [1:0] b, input string tag);
      int lat, we_lo, oe_lo, bad_bus;
      lat = -1; we_lo = 0; oe_lo = 0; bad_bus = 0;
      @(negedge Clk);
      set_ch(ch, w, a, d, b);
      req[ch] = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge Clk);
         if (!SRAM_CE_N && SRAM_ADDR !== a) bad_bus++;
         if ((!SRAM_WE_N || !SRAM_OE_N) && {SRAM_UB_N, SRAM_LB_N} !== ~b) bad_bus++;
         if (!SRAM_WE_N) begin
            we_lo++;
            if (SRAM_DQ !== d) bad_bus++;
         end
         if (!SRAM_OE_N) oe_lo++;
         if (ack != '0) begin
            lat = k;
            break;
         end
      end
      chk({tag, "_ack"}, ack, 32'(1) << ch);
      chk({tag, "_lat"}, lat, WAIT_CYCLES + 1);
      chk({tag, "_we_cycles"}, we_lo, w ? WAIT_CYCLES : 0);
      chk({tag, "_oe_cycles"}, oe_lo, w ? 0 : WAIT_CYCLES);
      chk({tag, "_bus"}, bad_bus, 0);
      req[ch] = 1'b0;
      check_done(tag, ch);
   endtask

   // All channels keep requesting; each drops req on its ack and returns two cycles later.
   task automatic run_fair(input int n_grants);
      int hold [NUM_CH];
      logic [NUM_CH-1:0] exp_pend;
      int n, k, last, g;
      n = 0; k = 0; last = -1;
      @(negedge Clk);
      for (int c = 0; c < NUM_CH; c++) begin
         new_op(c);
         req[c]  = 1'b1;
         hold[c] = 0;
      end
      exp_pend = '1;
      while (n < n_grants && k < 200) begin
         @(negedge Clk);
         k++;
         for (int c = 0; c < NUM_CH; c++) begin
            if (hold[c] > 0) begin
               hold[c]--;
               if (hold[c] == 0) begin
                  new_op(c);
                  req[c] = 1'b1;
               end
            end
         end
         if (ack != '0) begin
            g = model_pick(exp_pend, model_rr);
            chk("fair_ack", ack, 32'(1) << g);
            if (n < 6) chk($sformatf("fair_order%0d", n), ack_idx(ack), dir_order[n]);
            if (last >= 0) chk("fair_gap", k - last, PERIOD);
            last = k;
            check_done("fair", g);
            req[g]   = 1'b0;
            hold[g]  = 2;
            exp_pend = '1;
            exp_pend[g] = 1'b0;
            n++;
            if (n == n_grants) req = '0;
         end
      end
      chk("fair_count", n, n_grants);
   endtask

   // main sequence
   initial begin
      int seen;
      Reset_n = 1'b0;
      req = '0; we = '0; addr = '0; wdata = '0; be = '0;
      repeat (3) @(negedge Clk);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'h1F);
      chk("rst_addr", SRAM_ADDR, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_state", dbg_state, 0);
      Reset_n = 1'b1;
      repeat (2) @(negedge Clk);

      run_fair(9);

      run_one(1, 1'b1, 20'h00012, 16'hBEEF, 2'b11, "wr_ch1");
      run_one(2, 1'b0, 20'h00012, 16'h0000, 2'b11, "rd_ch2");
      chk("rd_beef", rdata, 16'hBEEF);
      repeat (10) @(negedge Clk);
      chk("rdata_hold", rdata, 16'hBEEF);
      run_one(0, 1'b1, 20'h00012, 16'h12AB, 2'b01, "wr_be01");
      run_one(1, 1'b0, 20'h00012, 16'h0000, 2'b11, "rd_be01");
      run_one(1, 1'b1, 20'h00012, 16'h5555, 2'b00, "wr_be00");
      run_one(2, 1'b0, 20'h00012, 16'h0000, 2'b11, "rd_be00");

      repeat (30) begin
         run_one(int'($urandom_range(0, NUM_CH-1)), 1'($urandom_range(0, 1)), rand_addr(),
                 DATA_W'($urandom), 2'($urandom_range(0, 3)), "rand");
      end

      // reset in the second ACCESS cycle of a write
      @(negedge Clk);
      set_ch(2, 1'b1, 20'h000F0, 16'hC0DE, 2'b11);
      req[2] = 1'b1;
      @(negedge Clk);
      chk("mid_busy", busy, 1);
      @(negedge Clk);
      Reset_n = 1'b0;
      #1;
      chk("mid_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'h1F);
      chk("mid_busy_rst", busy, 0);
      chk("mid_ack_rst", ack, 0);
      chk("mid_addr_rst", SRAM_ADDR, 0);
      seen = 0;
      repeat (3) begin
         @(negedge Clk);
         if (ack != '0) seen++;
      end
      req[2] = 1'b0;
      Reset_n = 1'b1;
      exp_rdata = '0;
      model_rr = 0;
      repeat (6) begin
         @(negedge Clk);
         if (ack != '0) seen++;
      end
      chk("mid_no_ack", seen, 0);
      run_one(1, 1'b0, 20'h00012, 16'h0000, 2'b11, "rd_after_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
